// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Lines are four 32-bit words; refills and write-backs move whole lines over one req/ack channel.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic         memRead_i,
  input  logic         memWrite_i,
  input  logic [31:0]  Write_Data_i,
  output logic [31:0]  Read_Data_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_data_o,
  input  logic [127:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned TagBits = 28 - INDEX_BITS;
  localparam int unsigned Lines   = 1 << INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]   valid_q;
  logic [Lines-1:0]   dirty_q;
  logic [TagBits-1:0] tag_q  [Lines];
  logic [127:0]       data_q [Lines];

  logic [TagBits-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;

  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_data_q, mem_data_d;

  logic [TagBits-1:0]    addr_tag;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [1:0]            addr_word;
  logic                  unused_addr;

  assign addr_tag    = addr_i[31:4+INDEX_BITS];
  assign addr_idx    = addr_i[3+INDEX_BITS:4];
  assign addr_word   = addr_i[3:2];
  assign unused_addr = ^addr_i[1:0];

  logic access, hit, victim_dirty, write_hit, miss_start, fill_done;

  assign access       = memRead_i | memWrite_i;
  assign hit          = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign victim_dirty = valid_q[addr_idx] & dirty_q[addr_idx];
  assign write_hit    = (state_q == StIdle) && memWrite_i && hit;
  assign miss_start   = (state_q == StIdle) && access && !hit;
  assign fill_done    = (state_q == StAllocate) && mem_ack_i;

  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      StIdle: begin
        if (miss_start) begin
          miss_tag_d = addr_tag;
          miss_idx_d = addr_idx;
          mem_req_d  = 1'b1;
          if (victim_dirty) begin
            state_d    = StWriteback;
            mem_we_d   = 1'b1;
            mem_addr_d = {tag_q[addr_idx], addr_idx, 4'b0000};
            mem_data_d = data_q[addr_idx];
          end else begin
            state_d    = StAllocate;
            mem_we_d   = 1'b0;
            mem_addr_d = {addr_tag, addr_idx, 4'b0000};
          end
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          state_d    = StAllocate;
          mem_we_d   = 1'b0;
          mem_addr_d = {miss_tag_q, miss_idx_q, 4'b0000};
        end
      end
      StAllocate: begin
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done) begin
      valid_q[miss_idx_q] <= 1'b1;
      dirty_q[miss_idx_q] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[addr_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits guard their contents.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_q[miss_idx_q] <= mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (write_hit) begin
      data_q[addr_idx][{addr_word, 5'b00000} +: 32] <= Write_Data_i;
    end
  end

  always_comb begin
    Read_Data_o = '0;
    if ((state_q == StIdle) && memRead_i && !memWrite_i && hit) begin
      Read_Data_o = data_q[addr_idx][{addr_word, 5'b00000} +: 32];
    end
  end

  assign stall_o    = (state_q != StIdle) || miss_start;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, write hit, dirty/clean eviction, slow memory, reset.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic         memRead_i;
  logic         memWrite_i;
  logic [31:0]  Write_Data_i;
  logic [31:0]  Read_Data_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic [127:0] mem_data_i;
  logic         mem_ack_i;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] Line40  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] Line140 = {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};
  localparam logic [127:0] Line240 = {32'h88880003, 32'h77770002, 32'h66660001, 32'h55550000};
  localparam logic [127:0] Line80  = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .memRead_i    (memRead_i),
    .memWrite_i   (memWrite_i),
    .Write_Data_i (Write_Data_i),
    .Read_Data_o  (Read_Data_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle ack pulse carrying a fill line.
  task automatic ack_pulse(input logic [127:0] line);
    mem_data_i = line;
    mem_ack_i  = 1'b1;
    step();
    mem_ack_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; addr_i = '0; memRead_i = 1'b0; memWrite_i = 1'b0;
    Write_Data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    #1;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", mem_we_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_addr_o); end
    total++; if (mem_data_o !== 128'h0) begin bad++; $display("FAIL reset_data got=%h want=0", mem_data_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    total++; if (Read_Data_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", Read_Data_o); end
  endtask

  task automatic test_cold_read();
    addr_i = 32'h44; memRead_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL cold_stall0 got=%b want=1", stall_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL cold_req0 got=%b want=0", mem_req_o); end
    step();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL cold_req got=%b want=1", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL cold_we got=%b want=0", mem_we_o); end
    total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL cold_addr got=%h want=40", mem_addr_o); end
    step(); step();
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL cold_stall_wait got=%b want=1", stall_o); end
    ack_pulse(Line40);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL cold_stall_done got=%b want=0", stall_o); end
    total++; if (Read_Data_o !== 32'hBBBB0001) begin bad++; $display("FAIL cold_rdata got=%h want=bbbb0001", Read_Data_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL cold_req_drop got=%b want=0", mem_req_o); end
  endtask

  task automatic test_write_hit();
    // Both enables set: treated as a store, so no load data is returned.
    memRead_i = 1'b1; memWrite_i = 1'b1; addr_i = 32'h44; Write_Data_i = 32'h12345678;
    #1;
    total++; if (Read_Data_o !== 32'h0) begin bad++; $display("FAIL both_rdata got=%h want=0", Read_Data_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL both_stall got=%b want=0", stall_o); end
    step();
    memWrite_i = 1'b0;
    #1;
    total++; if (Read_Data_o !== 32'h12345678) begin bad++; $display("FAIL both_read got=%h want=12345678", Read_Data_o); end
    memRead_i = 1'b0; memWrite_i = 1'b1; Write_Data_i = 32'hDEADBEEF;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL wr_stall got=%b want=0", stall_o); end
    step();
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL wr_req got=%b want=0", mem_req_o); end
    memWrite_i = 1'b0; memRead_i = 1'b1;
    #1;
    total++; if (Read_Data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_read got=%h want=deadbeef", Read_Data_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL wr_read_stall got=%b want=0", stall_o); end
    addr_i = 32'h40;
    #1;
    total++; if (Read_Data_o !== 32'hAAAA0000) begin bad++; $display("FAIL wr_word0 got=%h want=aaaa0000", Read_Data_o); end
    memRead_i = 1'b0;
    #1;
    total++; if (Read_Data_o !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h want=0", Read_Data_o); end
    step();
  endtask

  task automatic test_dirty_evict();
    memRead_i = 1'b1; addr_i = 32'h144;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL dirty_stall got=%b want=1", stall_o); end
    step();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL wb_req got=%b want=1", mem_req_o); end
    total++; if (mem_we_o !== 1'b1) begin bad++; $display("FAIL wb_we got=%b want=1", mem_we_o); end
    total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL wb_addr got=%h want=40", mem_addr_o); end
    total++; if (mem_data_o[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_word1 got=%h want=deadbeef", mem_data_o[63:32]); end
    total++; if (mem_data_o[31:0] !== 32'hAAAA0000) begin bad++; $display("FAIL wb_word0 got=%h want=aaaa0000", mem_data_o[31:0]); end
    step();
    ack_pulse(128'h0);
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL al_req got=%b want=1", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL al_we got=%b want=0", mem_we_o); end
    total++; if (mem_addr_o !== 32'h140) begin bad++; $display("FAIL al_addr got=%h want=140", mem_addr_o); end
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL al_stall got=%b want=1", stall_o); end
    ack_pulse(Line140);
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL dirty_hit_stall got=%b want=0", stall_o); end
    total++; if (Read_Data_o !== 32'h22220001) begin bad++; $display("FAIL dirty_hit_rdata got=%h want=22220001", Read_Data_o); end
  endtask

  task automatic test_clean_evict();
    addr_i = 32'h244;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL clean_stall got=%b want=1", stall_o); end
    step();
    total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL clean_req got=%b want=1", mem_req_o); end
    total++; if (mem_we_o !== 1'b0) begin bad++; $display("FAIL clean_we got=%b want=0", mem_we_o); end
    total++; if (mem_addr_o !== 32'h240) begin bad++; $display("FAIL clean_addr got=%h want=240", mem_addr_o); end
    ack_pulse(Line240);
    total++; if (Read_Data_o !== 32'h66660001) begin bad++; $display("FAIL clean_rdata got=%h want=66660001", Read_Data_o); end
  endtask

  task automatic test_slow_memory();
    addr_i = 32'h88;
    step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h80 || stall_o !== 1'b1) begin
        bad++;
        $display("FAIL slow_hold[%0d] got req=%b we=%b addr=%h stall=%b want 1 0 80 1",
                 i, mem_req_o, mem_we_o, mem_addr_o, stall_o);
      end
      step();
    end
    ack_pulse(Line80);
    total++; if (Read_Data_o !== 32'hC0DE0002) begin bad++; $display("FAIL slow_rdata got=%h want=c0de0002", Read_Data_o); end
    memRead_i = 1'b0;
    ack_pulse(128'h0);
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL stray_req got=%b want=0", mem_req_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL stray_stall got=%b want=0", stall_o); end
    memRead_i = 1'b1; addr_i = 32'h80;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL stray_hit_stall got=%b want=0", stall_o); end
    total++; if (Read_Data_o !== 32'hC0DE0000) begin bad++; $display("FAIL stray_hit_rdata got=%h want=c0de0000", Read_Data_o); end
    step();
  endtask

  task automatic test_reset_mid_wb();
    memRead_i = 1'b0; memWrite_i = 1'b1; addr_i = 32'h244; Write_Data_i = 32'hFEEDF00D;
    step();
    memWrite_i = 1'b0; memRead_i = 1'b1; addr_i = 32'h144;
    step();
    total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin bad++; $display("FAIL rwb_enter got req=%b we=%b want 1 1", mem_req_o, mem_we_o); end
    total++; if (mem_addr_o !== 32'h240) begin bad++; $display("FAIL rwb_addr got=%h want=240", mem_addr_o); end
    rst_i = 1'b0; memRead_i = 1'b0;
    #1;
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rwb_async_req got=%b want=0", mem_req_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rwb_async_stall got=%b want=0", stall_o); end
    step();
    rst_i = 1'b1; memRead_i = 1'b1; addr_i = 32'h44;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rwb_miss got=%b want=1", stall_o); end
    step();
    total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin bad++; $display("FAIL rwb_alloc got req=%b we=%b want 1 0", mem_req_o, mem_we_o); end
    total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL rwb_alloc_addr got=%h want=40", mem_addr_o); end
    ack_pulse(Line40);
    total++; if (Read_Data_o !== 32'hBBBB0001) begin bad++; $display("FAIL rwb_rdata got=%h want=bbbb0001", Read_Data_o); end
    memRead_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_clean_evict();
    test_slow_memory();
    test_reset_mid_wb();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
